// File: rtl/des_cbc_pkg.sv
// Shared widths and controller state type for the DES CBC feeder.
package des_cbc_pkg;

  localparam int unsigned N_K = 64;  // DES key width (parity bits included)
  localparam int unsigned N_B = 64;  // DES block width
  localparam int unsigned N_R = 16;  // rounds in the iterative core

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq,
    StOut
  } state_e;

endpackage

// File: rtl/des_cbc_ctrl.sv
// CBC chaining controller feeding one block at a time into the iterative DES core,
// with a block counter and a sticky error for a core that never acknowledges.
module des_cbc_ctrl
  import des_cbc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_K-1:0]   key,
  input  logic [N_B-1:0]   iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_B-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_B-1:0]   out_data,
  output logic [N_K-1:0]   core_k,
  output logic [N_B-1:0]   core_m,
  output logic             core_req,
  input  logic             core_ack,
  input  logic [N_B-1:0]   core_c,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TimerLast = TW'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [N_K-1:0]   core_k_q, core_k_d;
  logic [N_B-1:0]   core_m_q, core_m_d;
  logic [N_B-1:0]   chain_q, chain_d;
  logic [N_B-1:0]   out_q, out_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;

  always_comb begin
    state_d  = state_q;
    core_k_d = core_k_q;
    core_m_d = core_m_q;
    chain_d  = chain_q;
    out_d    = out_q;
    req_d    = req_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    unique case (state_q)
      StIdle, StLoad: begin
        // start wins over a pending block and restarts the chain
        if (start) begin
          core_k_d = key;
          chain_d  = iv;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = StLoad;
        end else if (state_q == StLoad && in_valid) begin
          core_m_d = in_data ^ chain_q;
          timer_d  = '0;
          req_d    = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (core_ack) begin
          out_d   = core_c;
          chain_d = core_c;
          req_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StOut;
        end else if (timer_q == TimerLast) begin
          // core is stuck: drop the block and wait for a fresh start
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StOut: begin
        if (out_ready) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      core_k_q <= '0;
      core_m_q <= '0;
      chain_q  <= '0;
      out_q    <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      core_k_q <= core_k_d;
      core_m_q <= core_m_d;
      chain_q  <= chain_d;
      out_q    <= out_d;
      req_q    <= req_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
    end
  end

  assign in_ready  = (state_q == StLoad) && !start;
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_q;
  assign core_k    = core_k_q;
  assign core_m    = core_m_q;
  assign core_req  = req_q;
  assign blk_cnt   = cnt_q;
  assign err       = err_q;

endmodule
